// File: rtl/flash_boot_loader_pkg.sv
// Shared bus widths, boot-loader state encoding and default image locations.
package flash_boot_loader_pkg;

  localparam int WB_AddrBus   = 32;
  localparam int WB_DataBus   = 32;
  localparam int FlashDataBus = 16;

  localparam logic [WB_AddrBus-1:0] BOOT_FLASH_BASE = 32'h1E00_0000;
  localparam logic [WB_AddrBus-1:0] BOOT_SRAM_BASE  = 32'h0000_0000;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_CHECK  = 4'd1,
    ST_RD_LO  = 4'd2,
    ST_GAP_LO = 4'd3,
    ST_RD_HI  = 4'd4,
    ST_GAP_HI = 4'd5,
    ST_WR     = 4'd6,
    ST_GAP_WR = 4'd7,
    ST_DONE   = 4'd8,
    ST_ERROR  = 4'd9
  } boot_state_e;

  // True for the states that hold a bus request open.
  function automatic logic is_request(input boot_state_e s);
    return (s == ST_RD_LO) || (s == ST_RD_HI) || (s == ST_WR);
  endfunction

endpackage

// File: rtl/flash_boot_loader_ack_timer.sv
// Counts the cycles a bus request has waited for ack and flags expiry on the
// TIMEOUT-th unacknowledged cycle, so the FSM leaves on that same edge.
module boot_ack_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [15:0] LIMIT_M1 = 16'(TIMEOUT - 1);

  logic [15:0] count_r;

  // Wait-cycle counter; clear takes priority so each request starts from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= 16'd0;
    end else if (clr) begin
      count_r <= 16'd0;
    end else if (en) begin
      count_r <= count_r + 16'd1;
    end else begin
      count_r <= count_r;
    end
  end

  // An ack in the final cycle drops en, so completion beats expiry.
  assign expired = en && (count_r == LIMIT_M1);

endmodule

// File: rtl/flash_boot_loader.sv
// Post-reset bus master copying a boot image from 16-bit flash into 32-bit
// SRAM, two halfword reads packed per word write; releases the CPU when done.
module flash_boot_loader
  import flash_boot_loader_pkg::*;
#(
  parameter logic [WB_AddrBus-1:0] FLASH_BASE = BOOT_FLASH_BASE,
  parameter logic [WB_AddrBus-1:0] SRAM_BASE  = BOOT_SRAM_BASE,
  parameter int                    WORDS      = 1024,
  parameter int                    TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [WB_AddrBus-1:0] m_addr_o,
  output logic [WB_DataBus-1:0] m_data_o,
  input  logic [WB_DataBus-1:0] m_data_i,
  output logic                  m_select_o,
  output logic                  m_we_o,
  input  logic                  m_ack_i,
  output logic                  boot_done_o,
  output logic                  boot_err_o
);

  localparam int IDX_W = (WORDS > 0) ? $clog2(WORDS + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS);

  boot_state_e             state_r;
  boot_state_e             state_nxt_s;
  logic [IDX_W-1:0]        idx_r;
  logic [IDX_W-1:0]        idx_nxt_s;
  logic [FlashDataBus-1:0] lo_r;
  logic [FlashDataBus-1:0] hi_r;
  logic                    req_s;
  logic                    expired_s;
  logic                    sel_nxt_s;
  logic                    we_nxt_s;
  logic [WB_AddrBus-1:0]   addr_nxt_s;
  logic [WB_DataBus-1:0]   data_nxt_s;
  logic                    done_nxt_s;
  logic                    err_nxt_s;
  logic                    unused_hi_s;

  assign unused_hi_s = ^m_data_i[WB_DataBus-1:FlashDataBus];
  assign req_s       = is_request(state_r);

  function automatic logic [WB_AddrBus-1:0] word_offset(input logic [IDX_W-1:0] idx);
    return WB_AddrBus'(idx) << 2'd2;
  endfunction

  boot_ack_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_ack_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (!req_s),
    .en      (req_s && !m_ack_i),
    .expired (expired_s)
  );

  // Next-state and word-index logic; ack is only looked at in request states.
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    case (state_r)
      ST_IDLE:   state_nxt_s = ST_CHECK;
      ST_CHECK: begin
        if (idx_r == LAST_IDX) state_nxt_s = ST_DONE;
        else                   state_nxt_s = ST_RD_LO;
      end
      ST_RD_LO: begin
        if (m_ack_i)        state_nxt_s = ST_GAP_LO;
        else if (expired_s) state_nxt_s = ST_ERROR;
        else                state_nxt_s = ST_RD_LO;
      end
      ST_GAP_LO: state_nxt_s = ST_RD_HI;
      ST_RD_HI: begin
        if (m_ack_i)        state_nxt_s = ST_GAP_HI;
        else if (expired_s) state_nxt_s = ST_ERROR;
        else                state_nxt_s = ST_RD_HI;
      end
      ST_GAP_HI: state_nxt_s = ST_WR;
      ST_WR: begin
        if (m_ack_i) begin
          idx_nxt_s   = idx_r + IDX_W'(1);
          state_nxt_s = ST_GAP_WR;
        end else if (expired_s) begin
          state_nxt_s = ST_ERROR;
        end else begin
          state_nxt_s = ST_WR;
        end
      end
      ST_GAP_WR: state_nxt_s = ST_CHECK;
      ST_DONE:   state_nxt_s = ST_DONE;
      ST_ERROR:  state_nxt_s = ST_ERROR;
      default:   state_nxt_s = ST_ERROR;
    endcase
  end

  // Output values for the state being entered, so the registered bus signals
  // line up exactly with the state register.
  always_comb begin
    sel_nxt_s  = 1'b0;
    we_nxt_s   = 1'b0;
    addr_nxt_s = 32'h0000_0000;
    data_nxt_s = 32'h0000_0000;
    done_nxt_s = 1'b0;
    err_nxt_s  = 1'b0;
    case (state_nxt_s)
      ST_RD_LO: begin
        sel_nxt_s  = 1'b1;
        addr_nxt_s = FLASH_BASE + word_offset(idx_nxt_s);
      end
      ST_RD_HI: begin
        sel_nxt_s  = 1'b1;
        addr_nxt_s = FLASH_BASE + word_offset(idx_nxt_s) + 32'd2;
      end
      ST_WR: begin
        sel_nxt_s  = 1'b1;
        we_nxt_s   = 1'b1;
        addr_nxt_s = SRAM_BASE + word_offset(idx_nxt_s);
        data_nxt_s = {hi_r, lo_r};
      end
      ST_DONE:  done_nxt_s = 1'b1;
      ST_ERROR: err_nxt_s  = 1'b1;
      default: begin
        sel_nxt_s = 1'b0;
      end
    endcase
  end

  // State, index, halfword latches and registered bus outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      idx_r       <= '0;
      lo_r        <= 16'h0000;
      hi_r        <= 16'h0000;
      m_select_o  <= 1'b0;
      m_we_o      <= 1'b0;
      m_addr_o    <= 32'h0000_0000;
      m_data_o    <= 32'h0000_0000;
      boot_done_o <= 1'b0;
      boot_err_o  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      idx_r   <= idx_nxt_s;
      if ((state_r == ST_RD_LO) && m_ack_i) lo_r <= m_data_i[FlashDataBus-1:0];
      if ((state_r == ST_RD_HI) && m_ack_i) hi_r <= m_data_i[FlashDataBus-1:0];
      m_select_o  <= sel_nxt_s;
      m_we_o      <= we_nxt_s;
      m_addr_o    <= addr_nxt_s;
      m_data_o    <= data_nxt_s;
      boot_done_o <= done_nxt_s;
      boot_err_o  <= err_nxt_s;
    end
  end

endmodule

// File: tb/tb_flash_boot_loader.sv
// Directed bench: a 2-word copy under several slave timings and a mid-copy
// reset, plus an empty image and an ack timeout on side instances.
module tb_flash_boot_loader;

  localparam logic [31:0] FB = 32'h1E00_0000;
  localparam logic [31:0] SB = 32'h0000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rst_aux;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        m_sel, m_we, m_ack, done, err;
  logic [31:0] aux_rdata;
  logic        aux_ack;
  logic [31:0] a0_addr, a0_wdata, at_addr, at_wdata;
  logic        a0_sel, a0_we, a0_done, a0_err;
  logic        at_sel, at_we, at_done, at_err;
  logic        sel0_seen = 1'b0;

  int n_chk = 0;
  int n_err = 0;
  int hold_left = 0;

  flash_boot_loader #(.FLASH_BASE(FB), .SRAM_BASE(SB), .WORDS(2), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst), .m_addr_o(m_addr), .m_data_o(m_wdata), .m_data_i(m_rdata),
    .m_select_o(m_sel), .m_we_o(m_we), .m_ack_i(m_ack), .boot_done_o(done), .boot_err_o(err));

  flash_boot_loader #(.FLASH_BASE(FB), .SRAM_BASE(SB), .WORDS(0), .TIMEOUT(255)) dut_empty (
    .clk(clk), .rst(rst_aux), .m_addr_o(a0_addr), .m_data_o(a0_wdata), .m_data_i(aux_rdata),
    .m_select_o(a0_sel), .m_we_o(a0_we), .m_ack_i(aux_ack), .boot_done_o(a0_done), .boot_err_o(a0_err));

  flash_boot_loader #(.FLASH_BASE(FB), .SRAM_BASE(SB), .WORDS(2), .TIMEOUT(4)) dut_tmo (
    .clk(clk), .rst(rst_aux), .m_addr_o(at_addr), .m_data_o(at_wdata), .m_data_i(aux_rdata),
    .m_select_o(at_sel), .m_we_o(at_we), .m_ack_i(aux_ack), .boot_done_o(at_done), .boot_err_o(at_err));

  always @(negedge clk) begin
    if (!rst_aux && a0_sel) sel0_seen <= 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock of idle bus, letting any held ack run out.
  task automatic tick();
    if (hold_left > 0) hold_left--;
    else m_ack = 1'b0;
    @(negedge clk);
  endtask

  // Waits for the next request, checks its idle gap, address, direction and
  // write data (also while stalled), then acks after lat cycles.
  task automatic bus_txn(input string tag, input logic [31:0] ea, input logic ewe,
                         input logic [31:0] ed, input logic [31:0] rd, input int lat,
                         input int hold, input int egap, input bit do_ack);
    int gap;
    gap = 0;
    for (int k = 0; k < 40; k++) begin
      if (hold_left > 0) hold_left--;
      else m_ack = 1'b0;
      if (m_sel) break;
      gap++;
      @(negedge clk);
    end
    chk({tag, " sel"}, 32'(m_sel), 32'd1);
    chk({tag, " gap"}, 32'(gap), 32'(egap));
    chk({tag, " addr"}, m_addr, ea);
    chk({tag, " we"}, 32'(m_we), 32'(ewe));
    if (ewe) chk({tag, " wdata"}, m_wdata, ed);
    for (int i = 1; i < lat; i++) begin
      @(negedge clk);
      chk({tag, " wait sel"}, 32'(m_sel), 32'd1);
      chk({tag, " wait addr"}, m_addr, ea);
      if (ewe) chk({tag, " wait wdata"}, m_wdata, ed);
    end
    if (do_ack) begin
      m_rdata = rd;
      m_ack   = 1'b1;
      @(negedge clk);
      chk({tag, " sel drop"}, 32'(m_sel), 32'd0);
      hold_left = hold;
    end
  endtask

  // Full 2-word copy; read data carries a junk upper half that must be dropped.
  task automatic copy2(input string tag, input logic [15:0] h0, input logic [15:0] h1,
                       input logic [15:0] h2, input logic [15:0] h3, input int lat,
                       input int hold, input int last_hold);
    bus_txn({tag, " rd0lo"}, FB + 32'd0, 1'b0, 32'd0, {16'hDEAD, h0}, lat, hold, 2, 1'b1);
    bus_txn({tag, " rd0hi"}, FB + 32'd2, 1'b0, 32'd0, {16'hDEAD, h1}, lat, hold, 1, 1'b1);
    bus_txn({tag, " wr0"},   SB + 32'd0, 1'b1, {h1, h0}, 32'd0, lat, hold, 1, 1'b1);
    bus_txn({tag, " rd1lo"}, FB + 32'd4, 1'b0, 32'd0, {16'hDEAD, h2}, lat, hold, 2, 1'b1);
    bus_txn({tag, " rd1hi"}, FB + 32'd6, 1'b0, 32'd0, {16'hDEAD, h3}, lat, hold, 1, 1'b1);
    bus_txn({tag, " wr1"},   SB + 32'd4, 1'b1, {h3, h2}, 32'd0, lat, last_hold, 1, 1'b1);
    tick();
    chk({tag, " done early"}, 32'(done), 32'd0);
    tick();
    chk({tag, " done"}, 32'(done), 32'd1);
    chk({tag, " err"}, 32'(err), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk({tag, " idle sel"}, 32'(m_sel), 32'd0);
      chk({tag, " done held"}, 32'(done), 32'd1);
    end
  endtask

  task automatic reset_main();
    rst = 1'b1;
    m_ack = 1'b0;
    hold_left = 0;
    repeat (2) @(negedge clk);
    chk("rst sel", 32'(m_sel), 32'd0);
    chk("rst we", 32'(m_we), 32'd0);
    chk("rst addr", m_addr, 32'd0);
    chk("rst wdata", m_wdata, 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst err", 32'(err), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rst_aux = 1'b1;
    m_ack = 1'b0; m_rdata = 32'd0;
    aux_ack = 1'b0; aux_rdata = 32'd0;
    repeat (3) @(negedge clk);
    chk("aux rst done0", 32'(a0_done), 32'd0);
    chk("aux rst tmo err", 32'(at_err), 32'd0);

    // Empty image and never-acking flash, released together.
    rst_aux = 1'b0;
    @(negedge clk);
    chk("empty done c1", 32'(a0_done), 32'd0);
    chk("tmo sel c1", 32'(at_sel), 32'd0);
    @(negedge clk);
    chk("empty done c2", 32'(a0_done), 32'd1);
    chk("tmo sel c2", 32'(at_sel), 32'd1);
    chk("tmo addr", at_addr, FB);
    chk("tmo we", 32'(at_we), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("tmo wait sel", 32'(at_sel), 32'd1);
      chk("tmo wait err", 32'(at_err), 32'd0);
      chk("tmo wait addr", at_addr, FB);
    end
    @(negedge clk);
    chk("tmo err", 32'(at_err), 32'd1);
    chk("tmo sel off", 32'(at_sel), 32'd0);
    chk("tmo done", 32'(at_done), 32'd0);
    repeat (3) @(negedge clk);
    chk("tmo err sticky", 32'(at_err), 32'd1);
    chk("tmo sel still off", 32'(at_sel), 32'd0);
    chk("empty done held", 32'(a0_done), 32'd1);
    chk("empty err", 32'(a0_err), 32'd0);
    chk("empty no select", 32'(sel0_seen), 32'd0);

    // Single-cycle acks.
    reset_main();
    copy2("fast", 16'h1111, 16'h2222, 16'h3333, 16'h4444, 1, 0, 0);

    // Slow slave: ack on the 5th request cycle, held into the gaps.
    reset_main();
    copy2("slow", 16'hA1A1, 16'hB2B2, 16'hC3C3, 16'hD4D4, 5, 1, 3);

    // Reset while the second word's write is pending.
    reset_main();
    bus_txn("pre rd0lo", FB + 32'd0, 1'b0, 32'd0, 32'h0000_5A01, 1, 0, 2, 1'b1);
    bus_txn("pre rd0hi", FB + 32'd2, 1'b0, 32'd0, 32'h0000_5A02, 1, 0, 1, 1'b1);
    bus_txn("pre wr0",   SB + 32'd0, 1'b1, 32'h5A02_5A01, 32'd0, 1, 0, 1, 1'b1);
    bus_txn("pre rd1lo", FB + 32'd4, 1'b0, 32'd0, 32'h0000_5A03, 1, 0, 2, 1'b1);
    bus_txn("pre rd1hi", FB + 32'd6, 1'b0, 32'd0, 32'h0000_5A04, 1, 0, 1, 1'b1);
    bus_txn("pre wr1",   SB + 32'd4, 1'b1, 32'h5A04_5A03, 32'd0, 1, 0, 1, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst sel", 32'(m_sel), 32'd0);
    chk("midrst we", 32'(m_we), 32'd0);
    chk("midrst done", 32'(done), 32'd0);
    rst = 1'b0;
    copy2("restart", 16'h0F01, 16'h0F02, 16'h0F03, 16'h0F04, 2, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
